i2c_target: RTL
===============

# i2c_target

I2C target (slave) endpoint that sits on the bus directly downstream of the team's I2C master and consumes the address, read/write and data bytes it produces. It oversamples `scl_in` and `sda_in` on the system clock, detects START and STOP, and matches a 7-bit address. It ACKs and drives data with an open-drain style enable, and exposes received bytes and transmit-byte requests on a simple parallel side. Multi-byte write and read transfers are supported; repeated START is honoured.

## Interface
- `ADDR`, 7'h52, 7-bit target address matched MSB-first.
- `clk`  in  1  system clock; must be at least 8× the SCL frequency, with SCL high and low phases each ≥4 clk.
- `rst`  in  1  reset; synchronous, active-high.
- `scl_in`  in  1  bus clock, asynchronous.
- `sda_in`  in  1  bus data, asynchronous.
- `sda_oe`  out  1  1 pulls SDA low, 0 releases it.
- `rx_data`  out  8  last received data byte (address bytes excluded).
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `tx_data`  in  8  byte to send on reads; sampled when `tx_ready` pulses.
- `tx_ready`  out  1  one-cycle pulse when `tx_data` is latched.
- `busy`  out  1  high from a matched address until STOP or NACK-end.
- `state`  out  3  current FSM state, for debug.

## Operation
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=0, `busy`=0, `state`=IDLE. Reset mid-transfer releases SDA on the next edge and discards partial bytes.
- Line conditioning: 2-flop synchroniser on each line plus a previous-value register. This gives `scl_rise`, `scl_fall`, `start` (SDA fall while SCL high) and `stop` (SDA rise while SCL high).
- All bytes are MSB-first. A 3-bit counter with an 8-bit shift register samples on `scl_rise`. SDA drive changes only on `scl_fall`.
- FSM states and encodings:
  - IDLE=0: waits for `start`.
  - ADDR=1: shifts 7 address bits plus the R/W bit.
    - On the 8th bit with a match: drive ACK (`sda_oe`=1) at the next `scl_fall` and go to ADDR_ACK; `busy` goes to 1.
    - On a mismatch: go to IDLE with SDA released.
  - ADDR_ACK=2: at the `scl_fall` ending the ACK clock:
    - Write (R/W=0): release SDA and go to RX.
    - Read (R/W=1): latch `tx_data`, pulse `tx_ready`, drive bit 7 and go to TX.
  - RX=3: shifts 8 bits. On the 8th `scl_rise`, `rx_data` is updated and `rx_valid` pulses the following cycle. The FSM then ACKs at the next `scl_fall` and goes to RX_ACK.
  - RX_ACK=4: releases SDA at the `scl_fall` ending ACK and returns to RX.
  - TX=5: drives `sda_oe`=~bit on each `scl_fall`. After the 8th bit's `scl_fall` it releases SDA and goes to TX_ACK.
  - TX_ACK=6: samples SDA on `scl_rise`.
    - Controller ACK (0): at the next `scl_fall`, latch `tx_data`, pulse `tx_ready`, drive bit 7 and go to TX.
    - Controller NACK (1): go to IDLE and clear `busy`.
- `start` in any state, including a repeated START, takes priority. It clears the counter, releases SDA and goes to ADDR.
- `stop` in any state releases SDA, clears `busy` and goes to IDLE. `start` and `stop` cannot coincide.
- General-call address 7'h00 is not matched unless `ADDR`=0.

## Timing
- Bus-to-detection latency: 3 clk from a line change to its edge/condition strobe.
- `sda_oe` changes in the clk cycle after `scl_fall` is detected, well inside the SCL low phase.
- `rx_valid` is exactly 1 clk wide; `rx_data` is held until the next byte completes.
- `tx_ready` is 1 clk wide. `tx_data` must be stable in that cycle, and the upstream user presents the next byte before the following ACK clock.
- Per byte, the FSM sits in the byte state for 8 SCL periods and the ACK state for 1 SCL period.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum, with encodings as above.
  - Constants `I2C_ACK`=0, `I2C_NACK`=1, `I2C_WRITE`=0, `I2C_READ`=1.
- Sub-module `i2c_line_sync`: synchronisers, edge detectors and START/STOP detection. It outputs `scl_rise`, `scl_fall`, `start`, `stop` and the synchronised `sda`.
- Top level holds the FSM, bit counter, shift register and output registers.

## Test plan
- Write 8'hA4 (0x52, W), data 8'h3C, STOP -> ACK on the address and data clocks; `rx_valid` pulses once with `rx_data`=8'h3C; `busy` returns to 0 after STOP.
- Address 0x53 (W) -> `sda_oe` stays 0 throughout; no `rx_valid`; `state`=IDLE until the next START.
- Read 8'hA5 with `tx_data`=8'hC3 then 8'h5A, controller ACKs then NACKs -> bus bits 11000011 then 01011010; exactly two `tx_ready` pulses; IDLE after the NACK.
- Write 3 bytes 8'h01, 8'h02, 8'hFF -> three `rx_valid` pulses in order; each byte ACKed.
- Write address, then repeated START, then read address -> RX aborts; ADDR re-entered; read proceeds with correct `tx_ready`.
- Assert `rst` mid-RX after 4 bits -> next cycle `sda_oe`=0, `state`=IDLE, `busy`=0; no `rx_valid`.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and bus constants for the I2C target.
package i2c_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6
  } state_e;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and strobes SCL edges plus START/STOP.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);
  // [1:0] synchroniser, [2] previous value; reset to the idle-high bus level
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q      <= '1;
      sda_q      <= '1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      scl_rise_o <= scl_q[1] & ~scl_q[2];
      scl_fall_o <= ~scl_q[1] & scl_q[2];
      start_o    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_o     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end
  assign sda_o = sda_q[2];
endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C target with parallel rx/tx byte interface.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic [2:0] state
);
  logic scl_rise, scl_fall, start, stop, sda;
  i2c_line_sync u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_in), .sda_i(sda_in),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall),
    .start_o(start), .stop_o(stop), .sda_o(sda)
  );
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rxd_q, rxd_d;
  logic oe_q, oe_d, rxv_q, rxv_d, busy_q, busy_d, rw_q, rw_d, pend_q, pend_d, load;
  logic [7:0] byte_w;
  assign byte_w = {sh_q[6:0], sda};
  // pend_q marks a finished byte (or controller ACK) awaiting the next SCL fall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rxd_d   = rxd_q;
    oe_d    = oe_q;
    rxv_d   = 1'b0;
    busy_d  = busy_q;
    rw_d    = rw_q;
    pend_d  = pend_q;
    load    = 1'b0;
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      pend_d  = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR:
          if (scl_rise) begin
            sh_d  = byte_w;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_w[7:1] == ADDR) begin
                busy_d = 1'b1;
                rw_d   = byte_w[0];
                pend_d = 1'b1;
              end else state_d = S_IDLE;
            end
          end else if (scl_fall && pend_q) begin
            oe_d    = 1'b1;
            pend_d  = 1'b0;
            state_d = S_ADDR_ACK;
          end
        S_ADDR_ACK:
          if (scl_fall) begin
            load    = rw_q == I2C_READ;
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = rw_q == I2C_WRITE ? S_RX : state_q;
          end
        S_RX:
          if (scl_rise) begin
            sh_d  = byte_w;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rxd_d  = byte_w;
              rxv_d  = 1'b1;
              pend_d = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            oe_d    = 1'b1;
            pend_d  = 1'b0;
            state_d = S_RX_ACK;
          end
        S_RX_ACK:
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = S_RX;
          end
        S_TX:
          if (scl_fall) begin
            cnt_d   = cnt_q + 3'd1;
            oe_d    = cnt_q == 3'd7 ? 1'b0 : ~sh_q[6];
            sh_d    = {sh_q[6:0], 1'b0};
            state_d = cnt_q == 3'd7 ? S_TX_ACK : S_TX;
          end
        S_TX_ACK:
          if (scl_rise) begin
            pend_d  = sda == I2C_ACK;
            busy_d  = sda == I2C_ACK;
            state_d = sda == I2C_NACK ? S_IDLE : S_TX_ACK;
          end else if (scl_fall && pend_q) load = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    if (load) begin
      sh_d    = tx_data;
      oe_d    = ~tx_data[7];
      cnt_d   = '0;
      pend_d  = 1'b0;
      state_d = S_TX;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rxd_q   <= '0;
      oe_q    <= 1'b0;
      rxv_q   <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rxd_q   <= rxd_d;
      oe_q    <= oe_d;
      rxv_q   <= rxv_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      pend_q  <= pend_d;
    end
  end
  assign sda_oe   = oe_q;
  assign rx_data  = rxd_q;
  assign rx_valid = rxv_q;
  assign tx_ready = load & ~rst;
  assign busy     = busy_q;
  assign state    = state_q;
endmodule
